invsqrt_req_arbiter: RTL and testbench

//  Shares one fixed-latency fp inverse-sqrt pipeline among NUM_REQ requesters.

---
 rtl/invsqrt_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_invsqrt_req_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invsqrt_req_arbiter.sv
// rtl/invsqrt_req_arbiter.sv - round-robin arbiter sharing one fixed-latency inverse-sqrt pipeline
// A requester-ID tag FIFO steers every pipeline result back to the requester that issued it.
module invsqrt_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PIPE_LAT  = 6,
  parameter int TAG_DEPTH = 8,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_enable,
  output logic                   idle,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   pipe_valid,
  output logic [30:0]            pipe_data,
  output logic                   pipe_err,
  output logic                   pipe_backprn,
  input  logic                   pipe_ready,
  input  logic [30:0]            pipe_result,
  input  logic                   pipe_error,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_error,
  input  logic [NUM_REQ-1:0]     resp_ready,
  output logic                   tag_ovf
);

  // The FIFO must cover every operand that can be inside the pipeline plus the issue register.
  localparam int DEPTH = (TAG_DEPTH < PIPE_LAT + 2) ? PIPE_LAT + 2 : TAG_DEPTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic              grant_any;
  logic              push;
  logic              pop;
  logic [31:0]       win_data;
  logic [ID_W-1:0]   tag_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A held response freezes the whole pipeline, so nothing new may enter either.
  assign pipe_backprn = ~|resp_valid | |(resp_valid & resp_ready);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant_any = (state == S_RUN) && pipe_backprn && (count < CNT_W'(DEPTH)) && found;
  assign req_ready = grant_any ? (NUM_REQ'(1) << win) : '0;
  assign win_data  = req_data[32*win +: 32];
  assign push      = grant_any;
  assign pop       = pipe_ready & pipe_backprn & (count != '0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_enable) begin
            state <= S_RUN;
            idle  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!cfg_enable) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (cfg_enable) begin
            state <= S_RUN;
          end else if (count == '0 && !(|(resp_valid & ~resp_ready))) begin
            state <= S_IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
      pipe_err   <= 1'b0;
    end else begin
      if (grant_any) rr_ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      if (pipe_backprn) begin
        pipe_valid <= grant_any;
        if (grant_any) begin
          pipe_data <= win_data[30:0];
          pipe_err  <= win_data[31] | (win_data[30:23] == 8'h00) | (win_data[30:23] == 8'hFF);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tag_ovf    <= 1'b0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A result with no tag to own it, or a tag with no room, means the bookkeeping is broken.
      if ((pipe_ready & pipe_backprn & (count == '0)) | (push & (count == CNT_W'(DEPTH))))
        tag_ovf <= 1'b1;
      if (pop) begin
        resp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
        resp_data  <= {1'b0, pipe_result};
        resp_error <= pipe_error;
      end else if (|(resp_valid & resp_ready)) begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_invsqrt_req_arbiter.sv
// tb/tb_invsqrt_req_arbiter.sv - randomized bench for invsqrt_req_arbiter with a pipeline model
// Expected results come from a grant-order scoreboard and a real-arithmetic inverse square root.
module tb_invsqrt_req_arbiter;
  localparam int N = 4;
  localparam int L = 6;
  localparam int D = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cfg_enable = 1'b0;
  logic            idle;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            pipe_valid;
  logic [30:0]     pipe_data;
  logic            pipe_err;
  logic            pipe_backprn;
  logic            pipe_ready;
  logic [30:0]     pipe_result;
  logic            pipe_error;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic            resp_error;
  logic [N-1:0]    resp_ready = '0;
  logic            tag_ovf;

  invsqrt_req_arbiter #(.NUM_REQ(N), .PIPE_LAT(L), .TAG_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .idle(idle),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_err(pipe_err),
    .pipe_backprn(pipe_backprn), .pipe_ready(pipe_ready), .pipe_result(pipe_result),
    .pipe_error(pipe_error), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .resp_ready(resp_ready), .tag_ovf(tag_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] invsqrt31(input logic [30:0] x);
    logic [63:0] b;
    logic [10:0] ye;
    real         r;
    if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) return {8'hFF, 23'h400000};
    b  = {1'b0, 11'({3'b000, x[30:23]} + 11'd896), x[22:0], 29'b0};
    r  = 1.0 / $sqrt($bitstoreal(b));
    b  = $realtobits(r);
    ye = b[62:52] - 11'd896;
    return {ye[7:0], b[51:29]};
  endfunction

  // Behavioural inverse-sqrt pipeline: L stages, frozen while backprn is low.
  logic        pv [L];
  logic [30:0] pd [L];
  logic        pe [L];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else if (pipe_backprn) begin
      pv[0] <= pipe_valid;
      pd[0] <= invsqrt31(pipe_data);
      pe[0] <= pipe_err;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end
  assign pipe_ready  = pv[L-1];
  assign pipe_result = pd[L-1];
  assign pipe_error  = pe[L-1];

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] data;
    logic        err;
    logic [31:0] gcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          gr_log[$];
  int          rs_log[$];
  logic [31:0] rd_log[$];
  logic [31:0] src_mem [N][64];
  int          src_head [N];
  int          src_tail [N];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rr_ptr = 0;
  int ready_pct = 100;
  int stall_left = 0;
  int stall_seen = 0;
  int err2_seen = 0;
  bit prev_en = 0;
  bit prev_acc = 1;
  bit lat_check = 0;
  bit stall_arm = 0;
  bit en_want = 0;
  bit rst_want = 1;

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_tail[i] - src_head[i];
    return s;
  endfunction

  function automatic logic expect_err(input logic [31:0] d);
    return d[31] | (d[30:23] == 8'h00) | (d[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(9))
      0:       return {1'b1, 8'($urandom_range(254, 1)), 23'($urandom)};
      1:       return {1'b0, 8'h00, 23'($urandom)};
      2:       return {1'b0, 8'hFF, 23'($urandom)};
      default: return {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
    endcase
  endfunction

  task automatic push_req(input int i, input logic [31:0] d);
    src_mem[i][src_tail[i] % 64] = d;
    src_tail[i]++;
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, score against the model.
  task automatic cycle();
    logic [N-1:0] acc;
    bit           bp;
    int           w;
    int           ew;
    exp_t         e;
    @(negedge clk);
    rstn       = ~rst_want;
    cfg_enable = en_want;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (src_head[i] != src_tail[i]);
      req_data[32*i +: 32] = req_valid[i] ? src_mem[i][src_head[i] % 64] : 32'h0;
    end
    if (stall_arm && resp_valid[1]) begin
      stall_left = 5;
      stall_arm  = 0;
    end
    for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(99) < ready_pct);
    if (stall_left > 0) resp_ready[1] = 1'b0;
    #1;
    if (!rstn) begin
      exp_q.delete();
      rr_ptr     = 0;
      prev_en    = 0;
      prev_acc   = 1;
      stall_left = 0;
      for (int i = 0; i < N; i++) src_head[i] = src_tail[i];
    end else begin
      acc = resp_valid & resp_ready;
      bp  = (resp_valid == '0) || (acc != '0);
      n_checks++;
      if (pipe_backprn !== bp) begin
        n_fail++; $display("FAIL backprn: got %0b expected %0b (cycle %0d)", pipe_backprn, bp, cyc);
      end
      n_checks++;
      if (tag_ovf !== 1'b0) begin
        n_fail++; $display("FAIL tag_ovf: got %0b expected 0 (cycle %0d)", tag_ovf, cyc);
      end
      n_checks++;
      if ($countones(resp_valid) > 1) begin
        n_fail++; $display("FAIL resp_onehot: got %b expected at most one bit", resp_valid);
      end
      n_checks++;
      if (idle && exp_q.size() != 0) begin
        n_fail++; $display("FAIL idle_busy: got idle=1 expected 0 with %0d in flight", exp_q.size());
      end
      if (stall_left > 0) begin
        if (!pipe_backprn) stall_seen++;
        stall_left--;
      end
      if (resp_valid != '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL spurious_resp: got resp_valid=%b expected none", resp_valid);
        end else begin
          if (prev_acc && lat_check) begin
            n_checks++;
            if (cyc - int'(exp_q[0].gcyc) != L + 2) begin
              n_fail++;
              $display("FAIL latency: got %0d expected %0d", cyc - int'(exp_q[0].gcyc), L + 2);
            end
          end
          n_checks++;
          if (resp_valid !== (N'(1) << exp_q[0].id)) begin
            n_fail++;
            $display("FAIL resp_owner: got %b expected %b", resp_valid, N'(1) << exp_q[0].id);
          end
          if (acc != '0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (resp_data !== {1'b0, invsqrt31(e.data[30:0])}) begin
              n_fail++;
              $display("FAIL resp_data: got %h expected %h (operand %h)", resp_data,
                       {1'b0, invsqrt31(e.data[30:0])}, e.data);
            end
            n_checks++;
            if (resp_error !== e.err) begin
              n_fail++; $display("FAIL resp_error: got %0b expected %0b (operand %h)", resp_error, e.err, e.data);
            end
            rs_log.push_back(int'(e.id));
            rd_log.push_back(resp_data);
            if (resp_error && e.id == 3'd2) err2_seen++;
          end
        end
      end
      n_checks++;
      if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
        n_fail++; $display("FAIL grant_shape: got req_ready=%b with req_valid=%b", req_ready, req_valid);
      end
      n_checks++;
      if (req_ready == '0 && prev_en && bp && req_valid != '0 && exp_q.size() < D) begin
        n_fail++; $display("FAIL missing_grant: got req_ready=0 expected a grant for %b", req_valid);
      end
      if (req_ready != '0) begin
        w  = $clog2(req_ready);
        ew = -1;
        for (int k = 0; k < N; k++)
          if (ew < 0 && req_valid[(rr_ptr + k) % N]) ew = (rr_ptr + k) % N;
        n_checks++;
        if (!prev_en || !bp) begin
          n_fail++; $display("FAIL grant_not_allowed: got req_ready=%b expected 0", req_ready);
        end
        n_checks++;
        if (w != ew) begin
          n_fail++; $display("FAIL rr_order: got requester %0d expected %0d", w, ew);
        end
        e.id   = 3'(w);
        e.data = req_data[32*w +: 32];
        e.err  = expect_err(e.data);
        e.gcyc = 32'(cyc);
        exp_q.push_back(e);
        gr_log.push_back(w);
        src_head[w]++;
        rr_ptr = (w + 1) % N;
      end
      prev_en  = cfg_enable;
      prev_acc = (resp_valid == '0) || (acc != '0);
    end
    cyc++;
  endtask

  task automatic wait_quiet(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || pending() != 0) begin
      n_fail++;
      $display("FAIL timeout: got %0d in flight and %0d pending expected 0", exp_q.size(), pending());
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_want = 1;
    en_want  = 0;
    repeat (3) cycle();
    rst_want = 0;
    push_req(0, 32'h3F800000);
    repeat (4) cycle();
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %0b expected 1", idle); end
    n_checks++;
    if (resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++;
    if (pipe_valid !== 1'b0 || pipe_err !== 1'b0 || pipe_data !== '0) begin
      n_fail++; $display("FAIL reset_issue: got v=%0b e=%0b d=%h expected 0", pipe_valid, pipe_err, pipe_data);
    end
    n_checks++;
    if (resp_data !== '0 || resp_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got d=%h e=%0b expected 0", resp_data, resp_error);
    end
    n_checks++;
    if (pipe_backprn !== 1'b1) begin n_fail++; $display("FAIL reset_backprn: got %0b expected 1", pipe_backprn); end
    src_head[0] = src_tail[0];
  endtask

  task automatic test_round_robin();
    gr_log.delete(); rs_log.delete(); rd_log.delete();
    ready_pct = 100;
    lat_check = 1;
    en_want   = 1;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < N; i++) push_req(i, 32'h3F800000);
    wait_quiet(100);
    n_checks++;
    if (gr_log.size() != 3 * N || rs_log.size() != 3 * N) begin
      n_fail++; $display("FAIL rr_count: got %0d/%0d expected %0d", gr_log.size(), rs_log.size(), 3 * N);
    end
    for (int k = 0; k < gr_log.size() && k < rs_log.size(); k++) begin
      n_checks++;
      if (gr_log[k] != k % N || rs_log[k] != k % N || rd_log[k] !== 32'h3F800000) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got grant %0d resp %0d data %h expected %0d/%0d/3f800000",
                 k, gr_log[k], rs_log[k], rd_log[k], k % N, k % N);
      end
    end
  endtask

  task automatic test_single();
    int g = -1;
    int r = -1;
    int n = 0;
    logic [N-1:0] rv = '0;
    logic [31:0]  rd = '0;
    push_req(0, 32'h40800000);
    while (g < 0 && n < 20) begin
      cycle();
      if (req_ready != '0) g = cyc - 1;
      n++;
    end
    n = 0;
    while (r < 0 && n < 20) begin
      cycle();
      if (resp_valid != '0) begin r = cyc - 1; rv = resp_valid; rd = resp_data; end
      n++;
    end
    n_checks++;
    if (rv !== 4'b0001) begin n_fail++; $display("FAIL single_owner: got %b expected 0001", rv); end
    n_checks++;
    if (rd !== 32'h3F000000) begin n_fail++; $display("FAIL single_data: got %h expected 3f000000", rd); end
    n_checks++;
    if (g < 0 || r < 0 || r - g != 8) begin
      n_fail++; $display("FAIL single_latency: got grant %0d resp %0d expected distance 8", g, r);
    end
    wait_quiet(20);
  endtask

  task automatic test_stall();
    lat_check  = 0;
    stall_seen = 0;
    stall_arm  = 1;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < N; i++) push_req(i, {1'b0, 8'($urandom_range(200, 50)), 23'($urandom)});
    wait_quiet(200);
    n_checks++;
    if (stall_seen != 5 || stall_arm) begin
      n_fail++; $display("FAIL stall_cycles: got %0d held cycles expected 5", stall_seen);
    end
  endtask

  task automatic test_error();
    err2_seen = 0;
    push_req(2, 32'hC0800000);
    push_req(0, 32'h7F800000);
    push_req(3, 32'h00000001);
    wait_quiet(50);
    n_checks++;
    if (err2_seen != 1) begin n_fail++; $display("FAIL error_req2: got %0d errored responses expected 1", err2_seen); end
  endtask

  task automatic test_drain();
    int n = 0;
    int p;
    ready_pct = 60;
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < N; i++) push_req(i, rand_operand());
    while (exp_q.size() < 6 && n < 60) begin cycle(); n++; end
    n_checks++;
    if (exp_q.size() < 6) begin n_fail++; $display("FAIL drain_fill: got %0d in flight expected >= 6", exp_q.size()); end
    en_want = 0;
    cycle();
    p = pending();
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin cycle(); n++; end
    n_checks++;
    if (exp_q.size() != 0 || pending() != p) begin
      n_fail++; $display("FAIL drain_flush: got %0d in flight, pending %0d expected 0, %0d", exp_q.size(), pending(), p);
    end
    n_checks++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL drain_early_idle: got %0b expected 0", idle); end
    cycle();
    n_checks++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %0b expected 1", idle); end
    en_want = 1;
    cycle();
    cycle();
    n_checks++;
    if (idle !== 1'b0) begin n_fail++; $display("FAIL reenable_idle: got %0b expected 0", idle); end
    wait_quiet(300);
  endtask

  task automatic test_random();
    ready_pct = 70;
    repeat (400) begin
      if ($urandom_range(3) == 0 && pending() < 24) push_req($urandom_range(N - 1), rand_operand());
      if ($urandom_range(49) == 0) en_want = ~en_want;
      cycle();
    end
    en_want = 1;
    wait_quiet(400);
  endtask

  task automatic test_reset_mid();
    ready_pct = 100;
    en_want   = 1;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < N; i++) push_req(i, {1'b0, 8'($urandom_range(200, 50)), 23'($urandom)});
    repeat (8) cycle();
    n_checks++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL midstream: got 0 in flight expected > 0"); end
    rst_want = 1;
    cycle();
    rst_want = 0;
    cycle();
    n_checks++;
    if (resp_valid !== '0 || idle !== 1'b1 || pipe_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got resp_valid=%b idle=%0b pipe_valid=%0b expected 0/1/0",
                         resp_valid, idle, pipe_valid);
    end
    rs_log.delete(); rd_log.delete();
    push_req(3, 32'h40800000);
    wait_quiet(40);
    n_checks++;
    if (rs_log.size() != 1 || rs_log[0] != 3 || rd_log[0] !== 32'h3F000000) begin
      n_fail++; $display("FAIL post_reset_route: got %0d responses expected one 3f000000 to requester 3", rs_log.size());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_single();
    test_stall();
    test_error();
    test_drain();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish within 1 ms");
    $fatal(1);
  end

endmodule
